// File: rtl/fpu_sequencer.sv
// fpu_sequencer: command scheduler in front of a single-precision fpu core.
// Queues requests in a command FIFO, issues them one at a time to the fpu,
// collects results into a response FIFO, and recovers a hung fpu with a
// watchdog timeout followed by a local fpu reset pulse.
// Ports:
//   wb_clk_i / wb_rst_i             clock, async active-high reset
//   cmd_valid/ready/opcode/round/a/b/tag   command push interface
//   rsp_valid/ready/data/flags/tag  response pop interface (head entry shown)
//   fpu_rstp/act/opcode/round_mp/in1p/in2p  fpu core drive
//   fpu_out/flags/done              fpu core result
//   busy                            state not IDLE or commands queued
//   timeout_cnt                     saturating watchdog event count
module fpu_sequencer #(
  parameter int unsigned CMD_DEPTH   = 4,
  parameter int unsigned RSP_DEPTH   = 4,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned TIMEOUT_CYC = 64,
  parameter int unsigned RST_CYC     = 4
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_opcode,
  input  logic [2:0]       cmd_round,
  input  logic [31:0]      cmd_a,
  input  logic [31:0]      cmd_b,
  input  logic [TAG_W-1:0] cmd_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic [8:0]       rsp_flags,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             fpu_rstp,
  output logic             fpu_act,
  output logic [2:0]       fpu_opcode,
  output logic [2:0]       fpu_round_mp,
  output logic [31:0]      fpu_in1p,
  output logic [31:0]      fpu_in2p,
  input  logic [31:0]      fpu_out,
  input  logic [7:0]       fpu_flags,
  input  logic             fpu_done,
  output logic             busy,
  output logic [7:0]       timeout_cnt
);

  localparam int unsigned CPW  = $clog2(CMD_DEPTH);
  localparam int unsigned CCW  = CPW + 1;
  localparam int unsigned RPW  = $clog2(RSP_DEPTH);
  localparam int unsigned RCW  = RPW + 1;
  localparam int unsigned WDW  = $clog2(TIMEOUT_CYC + 1);
  localparam int unsigned RSTW = $clog2(RST_CYC + 1);
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [8:0]  FLAG_INV = 9'h004;
  localparam logic [8:0]  FLAG_TMO = 9'h100;

  typedef enum logic [1:0] {IDLE, RUN, RECOVER} state_t;

  state_t state_q, state_d;

  logic [2:0]       cmd_op_mem  [CMD_DEPTH];
  logic [2:0]       cmd_rnd_mem [CMD_DEPTH];
  logic [31:0]      cmd_a_mem   [CMD_DEPTH];
  logic [31:0]      cmd_b_mem   [CMD_DEPTH];
  logic [TAG_W-1:0] cmd_tag_mem [CMD_DEPTH];
  logic [CPW-1:0]   cmd_wr_q, cmd_wr_d, cmd_rd_q, cmd_rd_d;
  logic [CCW-1:0]   cmd_cnt_q, cmd_cnt_d;

  logic [31:0]      rsp_data_mem  [RSP_DEPTH];
  logic [8:0]       rsp_flags_mem [RSP_DEPTH];
  logic [TAG_W-1:0] rsp_tag_mem   [RSP_DEPTH];
  logic [RPW-1:0]   rsp_wr_q, rsp_wr_d, rsp_rd_q, rsp_rd_d;
  logic [RCW-1:0]   rsp_cnt_q, rsp_cnt_d;

  logic [WDW-1:0]   wdog_q, wdog_d;
  logic [RSTW-1:0]  rcnt_q, rcnt_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             act_d, rstp_d;
  logic [2:0]       op_d, rnd_d;
  logic [31:0]      in1_d, in2_d;
  logic [7:0]       tcnt_d;

  logic             cmd_push, cmd_pop, rsp_push, rsp_pop, rsp_slot;
  logic [31:0]      push_data;
  logic [8:0]       push_flags;
  logic [TAG_W-1:0] push_tag;

  // Head of each FIFO
  logic [2:0] head_op;
  assign head_op   = cmd_op_mem[cmd_rd_q];
  assign rsp_data  = rsp_data_mem[rsp_rd_q];
  assign rsp_flags = rsp_flags_mem[rsp_rd_q];
  assign rsp_tag   = rsp_tag_mem[rsp_rd_q];

  // Next-state, issue and response-push decisions
  always_comb begin
    state_d    = state_q;
    wdog_d     = wdog_q;
    rcnt_d     = rcnt_q;
    tag_d      = tag_q;
    act_d      = fpu_act;
    rstp_d     = fpu_rstp;
    op_d       = fpu_opcode;
    rnd_d      = fpu_round_mp;
    in1_d      = fpu_in1p;
    in2_d      = fpu_in2p;
    tcnt_d     = timeout_cnt;
    cmd_pop    = 1'b0;
    rsp_push   = 1'b0;
    push_data  = '0;
    push_flags = '0;
    push_tag   = '0;
    cmd_push   = cmd_valid & cmd_ready;
    rsp_pop    = rsp_valid & rsp_ready;
    // A slot freed by a same-cycle pop counts as available
    rsp_slot   = (rsp_cnt_q < RCW'(RSP_DEPTH)) | rsp_pop;

    case (state_q)
      IDLE: begin
        if ((cmd_cnt_q != '0) && rsp_slot) begin
          cmd_pop = 1'b1;
          if (head_op > 3'd4) begin
            rsp_push   = 1'b1;
            push_data  = QNAN;
            push_flags = FLAG_INV;
            push_tag   = cmd_tag_mem[cmd_rd_q];
          end else begin
            op_d    = head_op;
            rnd_d   = cmd_rnd_mem[cmd_rd_q];
            in1_d   = cmd_a_mem[cmd_rd_q];
            in2_d   = cmd_b_mem[cmd_rd_q];
            tag_d   = cmd_tag_mem[cmd_rd_q];
            act_d   = 1'b1;
            wdog_d  = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        // done takes priority over a watchdog expiring on the same edge
        if (fpu_done) begin
          rsp_push   = 1'b1;
          push_data  = fpu_out;
          push_flags = {1'b0, fpu_flags};
          push_tag   = tag_q;
          act_d      = 1'b0;
          state_d    = IDLE;
        end else if (wdog_q == WDW'(TIMEOUT_CYC - 1)) begin
          rsp_push   = 1'b1;
          push_data  = QNAN;
          push_flags = FLAG_TMO;
          push_tag   = tag_q;
          act_d      = 1'b0;
          rstp_d     = 1'b1;
          rcnt_d     = '0;
          tcnt_d     = (timeout_cnt == 8'hFF) ? timeout_cnt : timeout_cnt + 8'd1;
          state_d    = RECOVER;
        end else begin
          wdog_d = wdog_q + WDW'(1);
        end
      end
      RECOVER: begin
        if (rcnt_q == RSTW'(RST_CYC - 1)) begin
          rstp_d  = 1'b0;
          state_d = IDLE;
        end else begin
          rcnt_d = rcnt_q + RSTW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    cmd_wr_d  = cmd_push ? cmd_wr_q + CPW'(1) : cmd_wr_q;
    cmd_rd_d  = cmd_pop  ? cmd_rd_q + CPW'(1) : cmd_rd_q;
    cmd_cnt_d = cmd_cnt_q + CCW'(cmd_push) - CCW'(cmd_pop);
    rsp_wr_d  = rsp_push ? rsp_wr_q + RPW'(1) : rsp_wr_q;
    rsp_rd_d  = rsp_pop  ? rsp_rd_q + RPW'(1) : rsp_rd_q;
    rsp_cnt_d = rsp_cnt_q + RCW'(rsp_push) - RCW'(rsp_pop);
  end

  // State, pointers and registered outputs
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q      <= IDLE;
      cmd_wr_q     <= '0;
      cmd_rd_q     <= '0;
      cmd_cnt_q    <= '0;
      rsp_wr_q     <= '0;
      rsp_rd_q     <= '0;
      rsp_cnt_q    <= '0;
      wdog_q       <= '0;
      rcnt_q       <= '0;
      tag_q        <= '0;
      fpu_act      <= 1'b0;
      fpu_rstp     <= 1'b0;
      fpu_opcode   <= '0;
      fpu_round_mp <= '0;
      fpu_in1p     <= '0;
      fpu_in2p     <= '0;
      timeout_cnt  <= '0;
      cmd_ready    <= 1'b0;
      rsp_valid    <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_rd_q     <= cmd_rd_d;
      cmd_cnt_q    <= cmd_cnt_d;
      rsp_wr_q     <= rsp_wr_d;
      rsp_rd_q     <= rsp_rd_d;
      rsp_cnt_q    <= rsp_cnt_d;
      wdog_q       <= wdog_d;
      rcnt_q       <= rcnt_d;
      tag_q        <= tag_d;
      fpu_act      <= act_d;
      fpu_rstp     <= rstp_d;
      fpu_opcode   <= op_d;
      fpu_round_mp <= rnd_d;
      fpu_in1p     <= in1_d;
      fpu_in2p     <= in2_d;
      timeout_cnt  <= tcnt_d;
      cmd_ready    <= cmd_cnt_d < CCW'(CMD_DEPTH);
      rsp_valid    <= rsp_cnt_d != '0;
      busy         <= (state_d != IDLE) || (cmd_cnt_d != '0);
    end
  end

  // Command storage; contents are don't-care until written
  always_ff @(posedge wb_clk_i) begin
    if (cmd_push) begin
      cmd_op_mem[cmd_wr_q]  <= cmd_opcode;
      cmd_rnd_mem[cmd_wr_q] <= cmd_round;
      cmd_a_mem[cmd_wr_q]   <= cmd_a;
      cmd_b_mem[cmd_wr_q]   <= cmd_b;
      cmd_tag_mem[cmd_wr_q] <= cmd_tag;
    end
  end

  // Response storage; cleared on reset so the head outputs read zero
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < RSP_DEPTH; i++) begin
        rsp_data_mem[i]  <= '0;
        rsp_flags_mem[i] <= '0;
        rsp_tag_mem[i]   <= '0;
      end
    end else if (rsp_push) begin
      rsp_data_mem[rsp_wr_q]  <= push_data;
      rsp_flags_mem[rsp_wr_q] <= push_flags;
      rsp_tag_mem[rsp_wr_q]   <= push_tag;
    end
  end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Self-checking bench for fpu_sequencer with a behavioural fpu model and an
// expected-response queue built from the commands as they are accepted.
module tb_fpu_sequencer;
  localparam int unsigned TAG_W = 4;

  logic             wb_clk_i = 1'b0;
  logic             wb_rst_i;
  logic             cmd_valid, cmd_ready;
  logic [2:0]       cmd_opcode, cmd_round;
  logic [31:0]      cmd_a, cmd_b;
  logic [TAG_W-1:0] cmd_tag;
  logic             rsp_valid, rsp_ready;
  logic [31:0]      rsp_data;
  logic [8:0]       rsp_flags;
  logic [TAG_W-1:0] rsp_tag;
  logic             fpu_rstp, fpu_act;
  logic [2:0]       fpu_opcode, fpu_round_mp;
  logic [31:0]      fpu_in1p, fpu_in2p, fpu_out;
  logic [7:0]       fpu_flags;
  logic             fpu_done;
  logic             busy;
  logic [7:0]       timeout_cnt;

  fpu_sequencer dut (
    .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_round(cmd_round), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag),
    .fpu_rstp(fpu_rstp), .fpu_act(fpu_act), .fpu_opcode(fpu_opcode),
    .fpu_round_mp(fpu_round_mp), .fpu_in1p(fpu_in1p), .fpu_in2p(fpu_in2p),
    .fpu_out(fpu_out), .fpu_flags(fpu_flags), .fpu_done(fpu_done),
    .busy(busy), .timeout_cnt(timeout_cnt)
  );

  initial forever #5 wb_clk_i = ~wb_clk_i;

  typedef struct packed {
    logic [31:0]      data;
    logic [8:0]       flags;
    logic [TAG_W-1:0] tag;
  } rsp_t;

  rsp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   act_cycles = 0, act_rises = 0, rstp_cycles = 0, push_waits = 0;
  bit   act_prev = 1'b0;
  int   fixed_lat = 0;
  bit   hang = 1'b0;

  // Behavioural fpu arithmetic stand-in (not IEEE; only needs to be a known function)
  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [2:0] rnd,
                                             input logic [31:0] a, input logic [31:0] b);
    if (op == 3'd0 && a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
    return (a * 32'd3) ^ b ^ {op, rnd, 26'd0};
  endfunction

  function automatic logic [7:0] ref_flags(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
    return a[7:0] ^ b[31:24] ^ {5'd0, op};
  endfunction

  // fpu core model: done after a latency counted while act is high
  initial begin
    int cnt = 0;
    int cur_lat = 1;
    fpu_done = 1'b0; fpu_out = '0; fpu_flags = '0;
    forever begin
      @(negedge wb_clk_i);
      if (wb_rst_i || fpu_rstp || !fpu_act) begin
        fpu_done = 1'b0; cnt = 0; fpu_out = $urandom;
      end else if (!fpu_done) begin
        if (cnt == 0) cur_lat = (fixed_lat != 0) ? fixed_lat : $urandom_range(1, 6);
        cnt++;
        if (!hang && cnt >= cur_lat) begin
          fpu_done  = 1'b1;
          fpu_out   = ref_result(fpu_opcode, fpu_round_mp, fpu_in1p, fpu_in2p);
          fpu_flags = ref_flags(fpu_opcode, fpu_in1p, fpu_in2p);
        end
      end
    end
  end

  // Activity monitor
  initial forever begin
    @(negedge wb_clk_i);
    if (fpu_act) act_cycles++;
    if (fpu_act && !act_prev) act_rises++;
    act_prev = fpu_act;
    if (fpu_rstp) rstp_cycles++;
  end

  task automatic push_cmd(input logic [2:0] op, input logic [2:0] rnd, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag);
    int   guard = 0;
    rsp_t e;
    @(negedge wb_clk_i);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_round = rnd; cmd_a = a; cmd_b = b; cmd_tag = tag;
    while (!cmd_ready && guard < 500) begin
      push_waits++;
      @(negedge wb_clk_i);
      guard++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL push_accept: cmd_ready=%b required 1 within 500 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    e.tag = tag;
    if (op > 3'd4)  begin e.data = 32'h7FC0_0000; e.flags = 9'h004; end
    else if (hang)  begin e.data = 32'h7FC0_0000; e.flags = 9'h100; end
    else            begin e.data = ref_result(op, rnd, a, b); e.flags = {1'b0, ref_flags(op, a, b)}; end
    @(posedge wb_clk_i);
    exp_q.push_back(e);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic drain(input int n, input int budget, input bit rand_ready);
    int   got = 0;
    int   cyc = 0;
    rsp_t e;
    while (got < n && cyc < budget) begin
      @(negedge wb_clk_i);
      cyc++;
      rsp_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (rsp_valid && rsp_ready) begin
        got++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_unexpected: got data=%h tag=%h, required none", rsp_data, rsp_tag);
        end else begin
          e = exp_q.pop_front();
          if (rsp_data !== e.data) begin
            n_fail++; $display("FAIL rsp_data: got %h required %h", rsp_data, e.data);
          end
          n_cmp++;
          if (rsp_flags !== e.flags) begin
            n_fail++; $display("FAIL rsp_flags: got %h required %h", rsp_flags, e.flags);
          end
          n_cmp++;
          if (rsp_tag !== e.tag) begin
            n_fail++; $display("FAIL rsp_tag: got %h required %h", rsp_tag, e.tag);
          end
        end
      end
    end
    if (got < n) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: got %0d responses required %0d", got, n);
    end
    @(posedge wb_clk_i);
    #1 rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    wb_rst_i = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_opcode = '0; cmd_round = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0;
    repeat (3) @(negedge wb_clk_i);
    n_cmp++;
    if ({cmd_ready, rsp_valid, fpu_act, fpu_rstp, busy, timeout_cnt, rsp_data} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: ready=%b valid=%b act=%b rstp=%b busy=%b tcnt=%h data=%h required all 0",
               cmd_ready, rsp_valid, fpu_act, fpu_rstp, busy, timeout_cnt, rsp_data);
    end
    wb_rst_i = 1'b0;
    #1;
    n_cmp++;
    if (cmd_ready !== 1'b0) begin
      n_fail++; $display("FAIL ready_before_clock: got %b required 0", cmd_ready);
    end
    @(posedge wb_clk_i); #1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL ready_after_clock: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_single_add();
    fixed_lat = 5; act_cycles = 0; act_rises = 0;
    push_cmd(3'd0, 3'd0, 32'h3F80_0000, 32'h4000_0000, 4'h5);
    drain(1, 100, 1'b0);
    n_cmp++;
    if (act_cycles != 5) begin
      n_fail++; $display("FAIL add_act_cycles: got %0d required 5", act_cycles);
    end
    n_cmp++;
    if (act_rises != 1) begin
      n_fail++; $display("FAIL add_act_rises: got %0d required 1", act_rises);
    end
    fixed_lat = 0;
  endtask

  task automatic test_back_to_back();
    act_rises = 0; push_waits = 0;
    fork
      for (int i = 0; i < 4; i++)
        push_cmd(3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)), $urandom, $urandom, TAG_W'(i));
      drain(4, 300, 1'b0);
    join
    n_cmp++;
    if (push_waits != 0) begin
      n_fail++; $display("FAIL b2b_cmd_ready: stalled %0d cycles required 0", push_waits);
    end
    n_cmp++;
    if (act_rises != 4) begin
      n_fail++; $display("FAIL b2b_act_gaps: act rises %0d required 4", act_rises);
    end
  endtask

  task automatic test_backpressure();
    act_rises = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++)
      push_cmd(3'($urandom_range(0, 4)), 3'($urandom_range(0, 7)), $urandom, $urandom, TAG_W'(i + 8));
    repeat (60) @(negedge wb_clk_i);
    n_cmp++;
    if ({rsp_valid, cmd_ready, fpu_act, busy} !== 4'b1001) begin
      n_fail++;
      $display("FAIL bp_stalled: valid=%b ready=%b act=%b busy=%b required 1 0 0 1",
               rsp_valid, cmd_ready, fpu_act, busy);
    end
    n_cmp++;
    if (act_rises != 4) begin
      n_fail++; $display("FAIL bp_issue_count: got %0d required 4", act_rises);
    end
    drain(8, 600, 1'b1);
  endtask

  task automatic test_illegal();
    act_rises = 0;
    push_cmd(3'd0, 3'd1, $urandom, $urandom, 4'h1);
    push_cmd(3'd6, 3'd2, $urandom, $urandom, 4'h2);
    push_cmd(3'd0, 3'd3, $urandom, $urandom, 4'h3);
    drain(3, 200, 1'b0);
    n_cmp++;
    if (act_rises != 2) begin
      n_fail++; $display("FAIL illegal_act_rises: got %0d required 2", act_rises);
    end
  endtask

  task automatic test_timeout();
    int guard = 0;
    hang = 1'b1; act_cycles = 0; rstp_cycles = 0;
    push_cmd(3'd2, 3'd0, $urandom, $urandom, 4'hA);
    drain(1, 200, 1'b0);
    while (busy && guard < 100) begin @(negedge wb_clk_i); guard++; end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL recover_end: busy=%b required 0", busy);
    end
    n_cmp++;
    if (act_cycles != 64) begin
      n_fail++; $display("FAIL tmo_act_cycles: got %0d required 64", act_cycles);
    end
    n_cmp++;
    if (rstp_cycles != 4) begin
      n_fail++; $display("FAIL tmo_rstp_cycles: got %0d required 4", rstp_cycles);
    end
    n_cmp++;
    if (timeout_cnt !== 8'd1) begin
      n_fail++; $display("FAIL tmo_count: got %0d required 1", timeout_cnt);
    end
    hang = 1'b0;
    push_cmd(3'd1, 3'd4, $urandom, $urandom, 4'hB);
    drain(1, 100, 1'b0);
  endtask

  task automatic test_random();
    fork
      for (int i = 0; i < 24; i++)
        push_cmd(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), $urandom, $urandom, TAG_W'($urandom));
      drain(24, 3000, 1'b1);
    join
  endtask

  task automatic test_reset_mid_run();
    int guard = 0;
    fixed_lat = 20;
    push_cmd(3'd3, 3'd0, $urandom, $urandom, 4'hC);
    while (!fpu_act && guard < 50) begin @(negedge wb_clk_i); guard++; end
    n_cmp++;
    if (fpu_act !== 1'b1) begin
      n_fail++; $display("FAIL midrun_act: got %b required 1", fpu_act);
    end
    #2 wb_rst_i = 1'b1;
    #1;
    n_cmp++;
    if ({fpu_act, fpu_rstp, rsp_valid, cmd_ready, busy, timeout_cnt, fpu_opcode, fpu_in1p} !== '0) begin
      n_fail++;
      $display("FAIL async_reset: act=%b rstp=%b valid=%b ready=%b busy=%b tcnt=%h op=%h in1=%h required all 0",
               fpu_act, fpu_rstp, rsp_valid, cmd_ready, busy, timeout_cnt, fpu_opcode, fpu_in1p);
    end
    @(negedge wb_clk_i);
    wb_rst_i = 1'b0;
    exp_q.delete();
    fixed_lat = 0;
    act_rises = 0;
    repeat (40) @(negedge wb_clk_i);
    n_cmp++;
    if ({rsp_valid, busy, cmd_ready} !== 3'b001) begin
      n_fail++;
      $display("FAIL post_reset_empty: valid=%b busy=%b ready=%b required 0 0 1", rsp_valid, busy, cmd_ready);
    end
    n_cmp++;
    if (act_rises != 0) begin
      n_fail++; $display("FAIL post_reset_no_issue: act rises %0d required 0", act_rises);
    end
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_back_to_back();
    test_backpressure();
    test_illegal();
    test_timeout();
    test_random();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
